// File: rtl/mealy_stream_ctrl_if.sv
// Requester-side handshake bundle for mealy_stream_ctrl: two byte requesters
// with their data buses and the grants returned by the controller.
interface mealy_stream_ctrl_if;
  logic       req_a;
  logic       req_b;
  logic [7:0] data_a;
  logic [7:0] data_b;
  logic       gnt_a;
  logic       gnt_b;

  modport master (
    output req_a,
    output req_b,
    output data_a,
    output data_b,
    input  gnt_a,
    input  gnt_b
  );

  modport slave (
    input  req_a,
    input  req_b,
    input  data_a,
    input  data_b,
    output gnt_a,
    output gnt_b
  );
endinterface

// File: rtl/mealy_stream_ctrl.sv
// Round-robin byte arbiter that serialises the granted byte MSB-first into an
// external Mealy detector and tallies its hits per byte and per requester.
module mealy_stream_ctrl (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               clr_cnt,
  mealy_stream_ctrl_if.slave bus,
  output logic               det_bit,
  output logic               det_valid,
  output logic               det_clr,
  input  logic               det_hit,
  output logic               busy,
  output logic               owner,
  output logic               done,
  output logic [3:0]         byte_hits,
  output logic [3:0]         hit_cnt_a,
  output logic [3:0]         hit_cnt_b
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state;
  logic       prio_b;
  logic [7:0] shift_reg;
  logic [2:0] bit_idx;
  logic       busy_q;
  logic       done_q;
  logic       clr_q;
  logic       valid_q;

  logic       any_req;
  logic       pick_b;
  logic       grant;

  // Grant is Mealy: it answers the request in the same IDLE cycle, and is
  // held low through reset and while the block is frozen.
  always_comb begin
    any_req   = bus.req_a | bus.req_b;
    pick_b    = bus.req_b & (~bus.req_a | prio_b);
    grant     = rst_n & ena & (state == IDLE) & any_req;
    bus.gnt_a = grant & ~pick_b;
    bus.gnt_b = grant & pick_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prio_b    <= 1'b0;
      shift_reg <= 8'h00;
      bit_idx   <= 3'd0;
      owner     <= 1'b0;
      byte_hits <= 4'd0;
      hit_cnt_a <= 4'd0;
      hit_cnt_b <= 4'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      clr_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner     <= pick_b;
            prio_b    <= ~pick_b;
            shift_reg <= pick_b ? bus.data_b : bus.data_a;
            byte_hits <= 4'd0;
            busy_q    <= 1'b1;
            clr_q     <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          clr_q   <= 1'b0;
          valid_q <= 1'b1;
          bit_idx <= 3'd0;
          state   <= SHIFT;
        end
        SHIFT: begin
          shift_reg <= {shift_reg[6:0], 1'b0};
          bit_idx   <= bit_idx + 3'd1;
          // Both the per-byte and per-requester tallies saturate instead of wrapping.
          if (det_hit) begin
            if (byte_hits != 4'd8) begin
              byte_hits <= byte_hits + 4'd1;
            end
            if (owner) begin
              if (hit_cnt_b != 4'hF) begin
                hit_cnt_b <= hit_cnt_b + 4'd1;
              end
            end else begin
              if (hit_cnt_a != 4'hF) begin
                hit_cnt_a <= hit_cnt_a + 4'd1;
              end
            end
          end
          if (bit_idx == 3'd7) begin
            valid_q <= 1'b0;
            done_q  <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
      // Placed last so a clear overrides a hit counted on the same edge.
      if (clr_cnt) begin
        hit_cnt_a <= 4'd0;
        hit_cnt_b <= 4'd0;
      end
    end
  end

  assign det_valid = valid_q & ena;
  assign det_clr   = clr_q & ena;
  assign done      = done_q & ena;
  assign det_bit   = det_valid & shift_reg[7];
  assign busy      = busy_q;

endmodule

// File: tb/tb_mealy_stream_ctrl.sv
// Directed self-checking bench for mealy_stream_ctrl: arbitration, serial
// timing, hit counting, saturation, enable stall and mid-byte reset.
module tb_mealy_stream_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       clr_cnt = 1'b0;
  logic       det_hit = 1'b0;
  logic       det_bit;
  logic       det_valid;
  logic       det_clr;
  logic       busy;
  logic       owner;
  logic       done;
  logic [3:0] byte_hits;
  logic [3:0] hit_cnt_a;
  logic [3:0] hit_cnt_b;

  int vectors = 0;
  int miscompares = 0;

  mealy_stream_ctrl_if bus();

  mealy_stream_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .clr_cnt   (clr_cnt),
    .bus       (bus),
    .det_bit   (det_bit),
    .det_valid (det_valid),
    .det_clr   (det_clr),
    .det_hit   (det_hit),
    .busy      (busy),
    .owner     (owner),
    .done      (done),
    .byte_hits (byte_hits),
    .hit_cnt_a (hit_cnt_a),
    .hit_cnt_b (hit_cnt_b)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    ena        = 1'b1;
    clr_cnt    = 1'b0;
    det_hit    = 1'b0;
    bus.req_a  = 1'b0;
    bus.req_b  = 1'b0;
    bus.data_a = 8'h00;
    bus.data_b = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  // Drives one complete byte transfer from IDLE; returns in the following IDLE cycle.
  task automatic send_byte(input bit sel_b, input logic [7:0] data,
                           input logic [7:0] hit_mask, input int clr_idx);
    if (sel_b) begin bus.req_b = 1'b1; bus.data_b = data; end
    else       begin bus.req_a = 1'b1; bus.data_a = data; end
    step();
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      det_hit = hit_mask[i];
      clr_cnt = (i == clr_idx);
      step();
    end
    det_hit = 1'b0;
    clr_cnt = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    ena       = 1'b1;
    bus.req_a = 1'b1;
    bus.req_b = 1'b1;
    det_hit   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({busy, owner, done, det_bit, det_valid, det_clr, bus.gnt_a, bus.gnt_b,
         byte_hits, hit_cnt_a, hit_cnt_b} !== 20'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got busy=%b own=%b done=%b bit=%b vld=%b clr=%b ga=%b gb=%b bh=%0d ca=%0d cb=%0d want all 0",
               busy, owner, done, det_bit, det_valid, det_clr, bus.gnt_a, bus.gnt_b,
               byte_hits, hit_cnt_a, hit_cnt_b);
    end
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    det_hit   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    vectors++;
    if ({busy, done, det_valid} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL idle_after_release: got busy=%b done=%b vld=%b want 000", busy, done, det_valid);
    end
  endtask

  task automatic test_single_byte();
    logic exp_bits [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    bus.req_a  = 1'b1;
    bus.data_a = 8'hB4;
    #1;
    vectors++;
    if ({bus.gnt_a, bus.gnt_b, busy} !== 3'b100) begin
      miscompares++;
      $display("[TB] FAIL single_grant: got ga=%b gb=%b busy=%b want 1 0 0", bus.gnt_a, bus.gnt_b, busy);
    end
    step();
    bus.req_a = 1'b0;
    #1;
    vectors++;
    if ({det_clr, det_valid, busy, owner, bus.gnt_a} !== 5'b10100) begin
      miscompares++;
      $display("[TB] FAIL single_load: got clr=%b vld=%b busy=%b own=%b ga=%b want 1 0 1 0 0",
               det_clr, det_valid, busy, owner, bus.gnt_a);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      vectors++;
      if ({det_valid, det_bit, det_clr} !== {1'b1, exp_bits[i], 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL single_bit%0d: got vld=%b bit=%b clr=%b want 1 %b 0",
                 i, det_valid, det_bit, det_clr, exp_bits[i]);
      end
    end
    step();
    vectors++;
    if ({done, busy, det_valid, byte_hits} !== {3'b110, 4'd0}) begin
      miscompares++;
      $display("[TB] FAIL single_done: got done=%b busy=%b vld=%b bh=%0d want 1 1 0 0",
               done, busy, det_valid, byte_hits);
    end
    step();
    vectors++;
    if ({done, busy, det_bit} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL single_after: got done=%b busy=%b bit=%b want 000", done, busy, det_bit);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.req_a  = 1'b1;
    bus.req_b  = 1'b1;
    bus.data_a = 8'h11;
    bus.data_b = 8'h22;
    for (int c = 0; c <= 23; c++) begin
      if (c > 0) step();
      if (c == 23) begin
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
      end
      #1;
      vectors++;
      if (c == 0 || c == 22) begin
        if ({bus.gnt_a, bus.gnt_b} !== 2'b10) begin
          miscompares++;
          $display("[TB] FAIL rr_grant_a_c%0d: got ga=%b gb=%b want 1 0", c, bus.gnt_a, bus.gnt_b);
        end
      end else if (c == 11) begin
        if ({bus.gnt_a, bus.gnt_b} !== 2'b01) begin
          miscompares++;
          $display("[TB] FAIL rr_grant_b_c%0d: got ga=%b gb=%b want 0 1", c, bus.gnt_a, bus.gnt_b);
        end
      end else if (c == 1 || c == 12 || c == 23) begin
        if ({det_clr, owner} !== {1'b1, (c == 12)}) begin
          miscompares++;
          $display("[TB] FAIL rr_owner_c%0d: got clr=%b own=%b want 1 %b", c, det_clr, owner, (c == 12));
        end
      end else begin
        if ({bus.gnt_a, bus.gnt_b} !== 2'b00) begin
          miscompares++;
          $display("[TB] FAIL rr_no_grant_c%0d: got ga=%b gb=%b want 0 0", c, bus.gnt_a, bus.gnt_b);
        end
      end
    end
    repeat (10) step();
  endtask

  task automatic test_hits_owner_b();
    logic [7:0] d = 8'h5A;
    do_reset();
    bus.req_b  = 1'b1;
    bus.data_b = d;
    det_hit    = 1'b1;
    #1;
    vectors++;
    if ({bus.gnt_a, bus.gnt_b} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL hits_grant_b: got ga=%b gb=%b want 0 1", bus.gnt_a, bus.gnt_b);
    end
    step();
    bus.req_b = 1'b0;
    #1;
    vectors++;
    if ({owner, det_clr} !== 2'b11) begin
      miscompares++;
      $display("[TB] FAIL hits_load: got own=%b clr=%b want 1 1", owner, det_clr);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      det_hit = (i == 2 || i == 5);
      #1;
      vectors++;
      if ({det_valid, det_bit} !== {1'b1, d[7-i]}) begin
        miscompares++;
        $display("[TB] FAIL hits_bit%0d: got vld=%b bit=%b want 1 %b", i, det_valid, det_bit, d[7-i]);
      end
    end
    step();
    det_hit = 1'b1;
    #1;
    vectors++;
    if ({done, byte_hits, hit_cnt_b, hit_cnt_a} !== {1'b1, 4'd2, 4'd2, 4'd0}) begin
      miscompares++;
      $display("[TB] FAIL hits_done: got done=%b bh=%0d cb=%0d ca=%0d want 1 2 2 0",
               done, byte_hits, hit_cnt_b, hit_cnt_a);
    end
    step();
    det_hit = 1'b0;
    #1;
    vectors++;
    if ({busy, byte_hits, hit_cnt_b, hit_cnt_a} !== {1'b0, 4'd2, 4'd2, 4'd0}) begin
      miscompares++;
      $display("[TB] FAIL hits_after_done: got busy=%b bh=%0d cb=%0d ca=%0d want 0 2 2 0",
               busy, byte_hits, hit_cnt_b, hit_cnt_a);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    send_byte(1'b0, 8'h3C, 8'hFF, -1);
    vectors++;
    if ({hit_cnt_a, byte_hits} !== {4'd8, 4'd8}) begin
      miscompares++;
      $display("[TB] FAIL sat_byte1: got ca=%0d bh=%0d want 8 8", hit_cnt_a, byte_hits);
    end
    send_byte(1'b0, 8'hC3, 8'hFF, -1);
    vectors++;
    if ({hit_cnt_a, byte_hits} !== {4'd15, 4'd8}) begin
      miscompares++;
      $display("[TB] FAIL sat_byte2: got ca=%0d bh=%0d want 15 8", hit_cnt_a, byte_hits);
    end
    send_byte(1'b0, 8'h81, 8'h0F, -1);
    vectors++;
    if ({hit_cnt_a, byte_hits, hit_cnt_b} !== {4'd15, 4'd4, 4'd0}) begin
      miscompares++;
      $display("[TB] FAIL sat_byte3: got ca=%0d bh=%0d cb=%0d want 15 4 0", hit_cnt_a, byte_hits, hit_cnt_b);
    end
    send_byte(1'b0, 8'h7E, 8'h07, 2);
    vectors++;
    if ({hit_cnt_a, byte_hits, hit_cnt_b} !== {4'd0, 4'd3, 4'd0}) begin
      miscompares++;
      $display("[TB] FAIL clr_wins: got ca=%0d bh=%0d cb=%0d want 0 3 0", hit_cnt_a, byte_hits, hit_cnt_b);
    end
  endtask

  task automatic test_ena_stall();
    logic exp_bits [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    bus.req_a  = 1'b1;
    bus.data_a = 8'hB4;
    for (int c = 0; c <= 15; c++) begin
      if (c > 0) step();
      if (c == 1) bus.req_a = 1'b0;
      if (c == 5) begin bus.req_b = 1'b1; bus.data_b = 8'hC3; end
      if (c >= 5 && c <= 7) begin ena = 1'b0; det_hit = 1'b1; end
      if (c == 8) begin ena = 1'b1; det_hit = 1'b0; end
      if (c == 15) bus.req_b = 1'b0;
      #1;
      vectors++;
      if (c == 0) begin
        if (bus.gnt_a !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL stall_grant: got ga=%b want 1", bus.gnt_a);
        end
      end else if (c == 1) begin
        if ({det_clr, det_valid} !== 2'b10) begin
          miscompares++;
          $display("[TB] FAIL stall_load: got clr=%b vld=%b want 1 0", det_clr, det_valid);
        end
      end else if (c <= 4) begin
        if ({det_valid, det_bit} !== {1'b1, exp_bits[c-2]}) begin
          miscompares++;
          $display("[TB] FAIL stall_pre_bit%0d: got vld=%b bit=%b want 1 %b", c - 2, det_valid, det_bit, exp_bits[c-2]);
        end
      end else if (c <= 7) begin
        if ({det_valid, det_bit, det_clr, done, busy, bus.gnt_b} !== 6'b000010) begin
          miscompares++;
          $display("[TB] FAIL stall_frozen_c%0d: got vld=%b bit=%b clr=%b done=%b busy=%b gb=%b want 0 0 0 0 1 0",
                   c, det_valid, det_bit, det_clr, done, busy, bus.gnt_b);
        end
      end else if (c <= 12) begin
        if ({det_valid, det_bit, done} !== {1'b1, exp_bits[c-5], 1'b0}) begin
          miscompares++;
          $display("[TB] FAIL stall_post_bit%0d: got vld=%b bit=%b done=%b want 1 %b 0",
                   c - 5, det_valid, det_bit, done, exp_bits[c-5]);
        end
      end else if (c == 13) begin
        if ({done, byte_hits, bus.gnt_b} !== {1'b1, 4'd0, 1'b0}) begin
          miscompares++;
          $display("[TB] FAIL stall_done: got done=%b bh=%0d gb=%b want 1 0 0", done, byte_hits, bus.gnt_b);
        end
      end else if (c == 14) begin
        if ({bus.gnt_a, bus.gnt_b, done} !== 3'b010) begin
          miscompares++;
          $display("[TB] FAIL stall_next_grant: got ga=%b gb=%b done=%b want 0 1 0", bus.gnt_a, bus.gnt_b, done);
        end
      end else begin
        if ({owner, det_clr} !== 2'b11) begin
          miscompares++;
          $display("[TB] FAIL stall_owner_b: got own=%b clr=%b want 1 1", owner, det_clr);
        end
      end
    end
    repeat (10) step();
  endtask

  task automatic test_reset_midbyte();
    do_reset();
    send_byte(1'b1, 8'h00, 8'h03, -1);
    vectors++;
    if (hit_cnt_b !== 4'd2) begin
      miscompares++;
      $display("[TB] FAIL midrst_setup: got cb=%0d want 2", hit_cnt_b);
    end
    bus.req_a  = 1'b1;
    bus.data_a = 8'hFF;
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) step();
      if (c == 1) bus.req_a = 1'b0;
      det_hit = (c >= 2);
    end
    #1;
    vectors++;
    if ({busy, det_valid, hit_cnt_a} !== {2'b11, 4'd4}) begin
      miscompares++;
      $display("[TB] FAIL midrst_inflight: got busy=%b vld=%b ca=%0d want 1 1 4", busy, det_valid, hit_cnt_a);
    end
    #2;
    bus.req_a = 1'b1;
    rst_n     = 1'b0;
    #1;
    vectors++;
    if ({busy, owner, done, det_bit, det_valid, det_clr, bus.gnt_a, bus.gnt_b,
         byte_hits, hit_cnt_a, hit_cnt_b} !== 20'h0) begin
      miscompares++;
      $display("[TB] FAIL midrst_async: got busy=%b own=%b done=%b bit=%b vld=%b clr=%b ga=%b gb=%b bh=%0d ca=%0d cb=%0d want all 0",
               busy, owner, done, det_bit, det_valid, det_clr, bus.gnt_a, bus.gnt_b,
               byte_hits, hit_cnt_a, hit_cnt_b);
    end
    bus.req_a = 1'b0;
    det_hit   = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      vectors++;
      if ({done, busy} !== 2'b00) begin
        miscompares++;
        $display("[TB] FAIL midrst_held_c%0d: got done=%b busy=%b want 0 0", c, done, busy);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    vectors++;
    if ({busy, done, hit_cnt_a, hit_cnt_b} !== 10'h0) begin
      miscompares++;
      $display("[TB] FAIL midrst_release: got busy=%b done=%b ca=%0d cb=%0d want 0 0 0 0",
               busy, done, hit_cnt_a, hit_cnt_b);
    end
    bus.req_b  = 1'b1;
    bus.data_b = 8'h80;
    #1;
    vectors++;
    if ({bus.gnt_a, bus.gnt_b} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL midrst_new_grant: got ga=%b gb=%b want 0 1", bus.gnt_a, bus.gnt_b);
    end
    step();
    bus.req_b = 1'b0;
    #1;
    vectors++;
    if ({det_clr, owner} !== 2'b11) begin
      miscompares++;
      $display("[TB] FAIL midrst_new_load: got clr=%b own=%b want 1 1", det_clr, owner);
    end
    step();
    vectors++;
    if ({det_valid, det_bit} !== 2'b11) begin
      miscompares++;
      $display("[TB] FAIL midrst_new_bit0: got vld=%b bit=%b want 1 1", det_valid, det_bit);
    end
    repeat (8) step();
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midrst_new_done: got done=%b want 1", done);
    end
    step();
  endtask

  initial begin
    bus.req_a  = 1'b0;
    bus.req_b  = 1'b0;
    bus.data_a = 8'h00;
    bus.data_b = 8'h00;
    $display("[TB] starting mealy_stream_ctrl directed tests");
    test_reset();
    test_single_byte();
    test_round_robin();
    test_hits_owner_b();
    test_saturation();
    test_ena_stall();
    test_reset_midbyte();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
